// File: rtl/rf_arb_pkg.sv
// Shared defaults, grant encoding and priority-state type for the register-file write arbiter.
package rf_arb_pkg;

  localparam int AW_DEF       = 5;
  localparam int DW_DEF       = 32;
  localparam int MAXBURST_DEF = 4;

  localparam logic GNT_CORE = 1'b0;
  localparam logic GNT_DBG  = 1'b1;

  typedef enum logic {
    PRI_C = 1'b0,
    PRI_D = 1'b1
  } pri_state_e;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Requester handshakes plus the register-file write port; master = requesters/port side, slave = arbiter.
interface rf_write_arbiter_if
  import rf_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic          c_valid;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_data;
  logic          c_ready;

  logic          d_valid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_data;
  logic          d_lock;
  logic          d_ready;

  logic          port_busy;

  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;

  modport master (
    output c_valid, c_addr, c_data,
    output d_valid, d_addr, d_data, d_lock,
    output port_busy,
    input  c_ready, d_ready,
    input  rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  c_valid, c_addr, c_data,
    input  d_valid, d_addr, d_data, d_lock,
    input  port_busy,
    output c_ready, d_ready,
    output rf_we, rf_waddr, rf_wdata
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter; increments by one on inc_i, sticks at all-ones.
// Output is the registered count, cleared by async active-low reset.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/rf_write_arbiter.sv
// Two-requester RF write arbiter: combinational ready, write reaches the port one cycle after acceptance.
// port_busy stalls both requesters; writes to register 0 are accepted and counted but never issued.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAXBURST = MAXBURST_DEF
) (
  input  logic                clk,
  input  logic                rst,
  rf_write_arbiter_if.slave   bus,
  output logic                last_gnt,
  output logic [7:0]          drop_cnt
);

  localparam int BW = (MAXBURST > 1) ? $clog2(MAXBURST + 1) : 1;

  pri_state_e    state_q, state_d;
  logic [BW-1:0] burst_q, burst_d;

  logic          rf_we_q;
  logic [AW-1:0] rf_waddr_q;
  logic [DW-1:0] rf_wdata_q;
  logic          last_gnt_q;

  logic          c_xfer, d_xfer, xfer;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic          sel_zero;

  // A lone requester always wins; on conflict the priority state decides.
  assign c_xfer = !bus.port_busy && bus.c_valid && (!bus.d_valid || (state_q == PRI_C));
  assign d_xfer = !bus.port_busy && bus.d_valid && (!bus.c_valid || (state_q == PRI_D));
  assign xfer   = c_xfer || d_xfer;

  assign bus.c_ready = c_xfer;
  assign bus.d_ready = d_xfer;

  assign sel_addr = c_xfer ? bus.c_addr : bus.d_addr;
  assign sel_data = c_xfer ? bus.c_data : bus.d_data;
  assign sel_zero = (sel_addr == '0);

  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    if (c_xfer) begin
      state_d = PRI_D;
      burst_d = '0;
    end else if (d_xfer) begin
      // Locked debug keeps priority until it has taken MAXBURST grants in a row.
      if ((state_q == PRI_D) && bus.d_lock && ((int'(burst_q) + 1) < MAXBURST)) begin
        state_d = PRI_D;
        burst_d = burst_q + BW'(1);
      end else begin
        state_d = PRI_C;
        burst_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= PRI_C;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      last_gnt_q <= GNT_DBG;
    end else begin
      rf_we_q <= xfer && !sel_zero;
      if (xfer && !sel_zero) begin
        rf_waddr_q <= sel_addr;
        rf_wdata_q <= sel_data;
      end
      if (xfer) begin
        last_gnt_q <= d_xfer ? GNT_DBG : GNT_CORE;
      end
    end
  end

  sat_counter #(
    .W (8)
  ) u_drop_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (xfer && sel_zero),
    .cnt_o (drop_cnt)
  );

  assign bus.rf_we    = rf_we_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;
  assign last_gnt     = last_gnt_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: inputs change and readies are sampled 1-2 time units after each rising edge.
module tb_rf_write_arbiter;

  logic       clk;
  logic       rst;
  logic       last_gnt;
  logic [7:0] drop_cnt;

  int n_checks;
  int n_errors;

  rf_write_arbiter_if #(.AW(5), .DW(32)) bus ();

  rf_write_arbiter #(
    .AW       (5),
    .DW       (32),
    .MAXBURST (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .last_gnt (last_gnt),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Grant pattern for both-valid phases: 1 = debug, 0 = core.
  logic alt_exp   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic burst_exp [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    logic [4:0] exp_addr;
    logic [31:0] exp_data;
    logic        seen_we;

    n_checks = 0;
    n_errors = 0;

    rst           = 1'b0;
    bus.c_valid   = 1'b0;
    bus.c_addr    = '0;
    bus.c_data    = '0;
    bus.d_valid   = 1'b0;
    bus.d_addr    = '0;
    bus.d_data    = '0;
    bus.d_lock    = 1'b0;
    bus.port_busy = 1'b0;

    // Reset values
    cyc();
    cyc();
    chk("rst_we",    bus.rf_we,    0);
    chk("rst_waddr", bus.rf_waddr, 0);
    chk("rst_wdata", bus.rf_wdata, 0);
    chk("rst_lgnt",  last_gnt,     1);
    chk("rst_drop",  drop_cnt,     0);

    // Single core write: ready in cycle 0, port write in cycle 1
    rst         = 1'b1;
    bus.c_valid = 1'b1;
    bus.c_addr  = 5'd5;
    bus.c_data  = 32'h1234;
    #1;
    chk("c0_cready", bus.c_ready, 1);
    chk("c0_dready", bus.d_ready, 0);
    cyc();
    chk("c0_we",    bus.rf_we,    1);
    chk("c0_waddr", bus.rf_waddr, 5);
    chk("c0_wdata", bus.rf_wdata, 32'h1234);
    chk("c0_lgnt",  last_gnt,     0);
    bus.c_valid = 1'b0;
    cyc();
    chk("idle_we",    bus.rf_we,    0);
    chk("idle_waddr", bus.rf_waddr, 5);

    // Alternation with d_lock=0; FSM is in PRI_D after the core write
    bus.c_valid = 1'b1;
    bus.c_addr  = 5'd10;
    bus.c_data  = 32'hC000_0010;
    bus.d_valid = 1'b1;
    bus.d_addr  = 5'd20;
    bus.d_data  = 32'hD000_0020;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("alt_dready", bus.d_ready, alt_exp[i]);
      chk("alt_cready", bus.c_ready, !alt_exp[i]);
      exp_addr = alt_exp[i] ? bus.d_addr : bus.c_addr;
      exp_data = alt_exp[i] ? bus.d_data : bus.c_data;
      cyc();
      chk("alt_we",    bus.rf_we,    1);
      chk("alt_waddr", bus.rf_waddr, exp_addr);
      chk("alt_wdata", bus.rf_wdata, exp_data);
      chk("alt_lgnt",  last_gnt,     alt_exp[i]);
      if (alt_exp[i]) begin
        bus.d_addr = bus.d_addr + 5'd1;
        bus.d_data = bus.d_data + 32'd1;
      end else begin
        bus.c_addr = bus.c_addr + 5'd1;
        bus.c_data = bus.c_data + 32'd1;
      end
    end

    // Locked burst from PRI_D: four debug grants, then core
    bus.d_lock = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("burst_dready", bus.d_ready, burst_exp[i]);
      chk("burst_cready", bus.c_ready, !burst_exp[i]);
      cyc();
      chk("burst_lgnt", last_gnt,  burst_exp[i]);
      chk("burst_we",   bus.rf_we, 1);
      if (burst_exp[i]) bus.d_addr = bus.d_addr + 5'd1;
      else              bus.c_addr = bus.c_addr + 5'd1;
    end
    bus.d_lock = 1'b0;

    // Three stalled cycles; FSM back in PRI_D, so debug wins afterwards
    bus.port_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_cready", bus.c_ready, 0);
      chk("stall_dready", bus.d_ready, 0);
      cyc();
      chk("stall_we",   bus.rf_we, 0);
      chk("stall_lgnt", last_gnt,  0);
    end
    bus.port_busy = 1'b0;
    #1;
    chk("post_dready", bus.d_ready, 1);
    chk("post_cready", bus.c_ready, 0);
    exp_addr = bus.d_addr;
    cyc();
    chk("post_we",    bus.rf_we,    1);
    chk("post_waddr", bus.rf_waddr, exp_addr);
    chk("post_lgnt",  last_gnt,     1);

    // 260 core writes to r0: accepted, never issued, counter saturates
    bus.d_valid = 1'b0;
    bus.c_addr  = 5'd0;
    bus.c_data  = 32'hDEAD_0000;
    #1;
    chk("r0_cready", bus.c_ready, 1);
    seen_we = 1'b0;
    for (int i = 0; i < 260; i++) begin
      cyc();
      if (bus.rf_we) seen_we = 1'b1;
      if (i == 2) chk("r0_drop3", drop_cnt, 3);
    end
    chk("r0_no_we", seen_we,  0);
    chk("r0_drop",  drop_cnt, 255);
    chk("r0_lgnt",  last_gnt, 0);

    // Debug write to r0 still updates last_gnt; counter stays saturated
    bus.c_valid = 1'b0;
    bus.d_valid = 1'b1;
    bus.d_addr  = 5'd0;
    #1;
    chk("r0d_dready", bus.d_ready, 1);
    cyc();
    chk("r0d_we",   bus.rf_we, 0);
    chk("r0d_lgnt", last_gnt,  1);
    chk("r0d_drop", drop_cnt,  255);

    // Reset the cycle after an accepted write: rf_we drops immediately
    bus.d_valid = 1'b0;
    bus.c_valid = 1'b1;
    bus.c_addr  = 5'd7;
    bus.c_data  = 32'hBEEF;
    cyc();
    chk("rst2_we_pre", bus.rf_we, 1);
    bus.c_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst2_we",    bus.rf_we,    0);
    chk("rst2_waddr", bus.rf_waddr, 0);
    chk("rst2_wdata", bus.rf_wdata, 0);
    chk("rst2_lgnt",  last_gnt,     1);
    chk("rst2_drop",  drop_cnt,     0);
    cyc();

    // First cycle out of reset: PRI_C, core wins a conflict
    rst         = 1'b1;
    bus.c_valid = 1'b1;
    bus.c_addr  = 5'd9;
    bus.c_data  = 32'h0000_0909;
    bus.d_valid = 1'b1;
    bus.d_addr  = 5'd3;
    #1;
    chk("rel_cready", bus.c_ready, 1);
    chk("rel_dready", bus.d_ready, 0);
    cyc();
    chk("rel_we",    bus.rf_we,    1);
    chk("rel_waddr", bus.rf_waddr, 9);
    chk("rel_wdata", bus.rf_wdata, 32'h0909);
    chk("rel_lgnt",  last_gnt,     0);

    bus.c_valid = 1'b0;
    bus.d_valid = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
